// File: rtl/wavelet_dec_seq_pkg.sv
// Shared definitions for the sym4 decomposition frame sequencer and its benches.
package wavelet_dec_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FEED  = 3'd1,
      ST_FLUSH = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam int unsigned NUM_LVL        = 5;
   localparam int unsigned DEF_FLUSH_BLKS = 8;
   localparam int unsigned DEF_QUIET_CYC  = 8;
   localparam int unsigned DEF_DRAIN_MAX  = 512;

   // LSB offset of level lvl (0 = L1) inside the packed lvl_cnt bus
   function automatic int unsigned lvl_cnt_lo(input int unsigned lvl, input int unsigned cnt_w);
      return lvl * cnt_w;
   endfunction

endpackage

// File: rtl/wavelet_dec_seq_lvl_counter.sv
// Saturating per-level output counter with synchronous clear and count enable.
module wavelet_lvl_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/wavelet_dec_seq.sv
// Frame sequencer: feeds frame_len real blocks into L1, flushes with zero blocks,
// waits for the five-level chain to go quiet and counts per-level outputs.
module wavelet_dec_seq
   import wavelet_dec_seq_pkg::*;
#(
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned FLUSH_BLKS = DEF_FLUSH_BLKS,
   parameter int unsigned QUIET_CYC  = DEF_QUIET_CYC,
   parameter int unsigned DRAIN_MAX  = DEF_DRAIN_MAX
) (
   input  logic                     clk_78_125,
   input  logic                     rstn,
   input  logic                     start,
   input  logic                     abort,
   input  logic [CNT_W-1:0]         frame_len,
   input  logic                     src_valid,
   output logic                     src_ready,
   output logic                     din_valid,
   output logic                     din_zero,
   input  logic [NUM_LVL-1:0]       lvl_valid,
   output logic [NUM_LVL*CNT_W-1:0] lvl_cnt,
   output logic                     busy,
   output logic                     done,
   output logic                     err_timeout
);

   localparam int unsigned FL_W = $clog2(FLUSH_BLKS + 1);
   localparam int unsigned QC_W = $clog2(QUIET_CYC + 1);
   localparam int unsigned DC_W = $clog2(DRAIN_MAX + 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  frame_len_q, frame_len_d;
   logic [CNT_W-1:0]  blk_cnt_q, blk_cnt_d;
   logic [FL_W-1:0]   flush_cnt_q, flush_cnt_d;
   logic [QC_W-1:0]   quiet_q, quiet_d;
   logic [DC_W-1:0]   cyc_q, cyc_d;
   logic              err_q, err_d;
   logic              din_valid_q, din_valid_d;
   logic              din_zero_q, din_zero_d;
   logic              cnt_clr_c;

   // Next-state and registered-output logic; abort overrides every transition
   always_comb begin
      state_d     = state_q;
      frame_len_d = frame_len_q;
      blk_cnt_d   = blk_cnt_q;
      flush_cnt_d = flush_cnt_q;
      quiet_d     = quiet_q;
      cyc_d       = cyc_q;
      err_d       = err_q;
      din_valid_d = 1'b0;
      din_zero_d  = 1'b0;
      cnt_clr_c   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               frame_len_d = frame_len;
               blk_cnt_d   = '0;
               flush_cnt_d = '0;
               err_d       = 1'b0;
               cnt_clr_c   = 1'b1;
               state_d     = (frame_len == '0) ? ST_FLUSH : ST_FEED;
            end
         end
         ST_FEED: begin
            if (src_valid) begin
               blk_cnt_d   = blk_cnt_q + CNT_W'(1);
               din_valid_d = 1'b1;
               if ((blk_cnt_q + CNT_W'(1)) == frame_len_q) state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            din_valid_d = 1'b1;
            din_zero_d  = 1'b1;
            flush_cnt_d = flush_cnt_q + FL_W'(1);
            if (flush_cnt_q == FL_W'(FLUSH_BLKS - 1)) begin
               quiet_d = '0;
               cyc_d   = '0;
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            cyc_d   = cyc_q + DC_W'(1);
            quiet_d = (lvl_valid == '0) ? (quiet_q + QC_W'(1)) : '0;
            if (quiet_d == QC_W'(QUIET_CYC)) begin
               state_d = ST_DONE;
            end else if (cyc_d == DC_W'(DRAIN_MAX)) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (abort && (state_q != ST_IDLE)) begin
         state_d     = ST_IDLE;
         err_d       = err_q;
         din_valid_d = 1'b0;
         din_zero_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_78_125 or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         frame_len_q <= '0;
         blk_cnt_q   <= '0;
         flush_cnt_q <= '0;
         quiet_q     <= '0;
         cyc_q       <= '0;
         err_q       <= 1'b0;
         din_valid_q <= 1'b0;
         din_zero_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_len_q <= frame_len_d;
         blk_cnt_q   <= blk_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         quiet_q     <= quiet_d;
         cyc_q       <= cyc_d;
         err_q       <= err_d;
         din_valid_q <= din_valid_d;
         din_zero_q  <= din_zero_d;
      end
   end

   assign src_ready   = (state_q == ST_FEED);
   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);
   assign din_valid   = din_valid_q;
   assign din_zero    = din_zero_q;
   assign err_timeout = err_q;

   for (genvar i = 0; i < NUM_LVL; i++) begin : g_lvl
      wavelet_lvl_counter #(.W(CNT_W)) u_cnt (
         .clk   (clk_78_125),
         .rst_n (rstn),
         .clr   (cnt_clr_c),
         .en    (lvl_valid[i] & busy),
         .cnt   (lvl_cnt[lvl_cnt_lo(i, CNT_W) +: CNT_W])
      );
   end

endmodule

// File: tb/tb_wavelet_dec_seq.sv
// Randomized self-checking bench: a frame timeline model predicts every output cycle by cycle.
module tb_wavelet_dec_seq;
   import wavelet_dec_seq_pkg::*;

   localparam int NT   = 1024;
   localparam int F    = 8;
   localparam int Q    = 8;
   localparam int DMAX = 512;
   localparam int TAIL = 4;

   logic        clk_78_125 = 1'b0;
   logic        rstn, start, abort, src_valid;
   logic [15:0] frame_len;
   logic [4:0]  lvl_valid;
   logic        src_ready, din_valid, din_zero, busy, done, err_timeout;
   logic [79:0] lvl_cnt;
   logic        src_ready4, din_valid4, din_zero4, busy4, done4, err_timeout4;
   logic [19:0] lvl_cnt4;

   always #5 clk_78_125 = ~clk_78_125;

   wavelet_dec_seq #(.CNT_W(16)) u_dut (
      .clk_78_125(clk_78_125), .rstn(rstn), .start(start), .abort(abort),
      .frame_len(frame_len), .src_valid(src_valid), .src_ready(src_ready),
      .din_valid(din_valid), .din_zero(din_zero), .lvl_valid(lvl_valid),
      .lvl_cnt(lvl_cnt), .busy(busy), .done(done), .err_timeout(err_timeout));

   wavelet_dec_seq #(.CNT_W(4)) u_dut4 (
      .clk_78_125(clk_78_125), .rstn(rstn), .start(start), .abort(abort),
      .frame_len(frame_len[3:0]), .src_valid(src_valid), .src_ready(src_ready4),
      .din_valid(din_valid4), .din_zero(din_zero4), .lvl_valid(lvl_valid),
      .lvl_cnt(lvl_cnt4), .busy(busy4), .done(done4), .err_timeout(err_timeout4));

   int n_chk = 0;
   int n_fail = 0;

   bit          sv [NT];
   bit          st [NT];
   logic [4:0]  lv [NT];
   logic [15:0] fl_in [NT];
   int          cnt_exp [5];
   bit          err_exp;

   task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [79:0] exp_cnt(input int w);
      logic [79:0] r = '0;
      int          sat = (1 << w) - 1;
      for (int i = 0; i < 5; i++) begin
         int v = (cnt_exp[i] > sat) ? sat : cnt_exp[i];
         for (int b = 0; b < w; b++) r[lvl_cnt_lo(i, w) + b] = v[b];
      end
      return r;
   endfunction

   function automatic logic [4:0] sparse_lv();
      logic [4:0] r;
      for (int b = 0; b < 5; b++) r[b] = ($urandom_range(0, 15) == 0);
      return r;
   endfunction

   // sv_mode: 0 always, 1 alternating, 2 random; lv_mode: 0 none, 1 sparse,
   // 2 sparse with L1 stuck high, 3 L5 high for busy cycles 1..20; ab_mode: 0 none, 1 flush cycle 2, 2 random
   task automatic run_frame(input int len, input int sv_mode, input int lv_mode,
                            input int ab_mode, input bit rnd_start);
      int t_last, f0, d0, done_t, abort_t, end_t, acc, q, pt;
      bit timeout, rdy_e, dv_e, dz_e, feed_pt, flush_pt;
      for (int t = 0; t < NT; t++) begin
         case (sv_mode)
            0:       sv[t] = 1'b1;
            1:       sv[t] = (t % 2 == 1);
            default: sv[t] = ($urandom_range(0, 2) != 0);
         endcase
         case (lv_mode)
            0:       lv[t] = '0;
            1:       lv[t] = sparse_lv();
            2:       lv[t] = sparse_lv() | 5'b00001;
            default: lv[t] = (t >= 1 && t <= 20) ? 5'b10000 : 5'b00000;
         endcase
         st[t]    = (t == 0) || (rnd_start && $urandom_range(0, 7) == 0);
         fl_in[t] = (t == 0) ? 16'(len) : 16'($urandom_range(0, 15));
      end
      acc = 0;
      t_last = 0;
      for (int t = 1; t < NT && acc < len; t++) begin
         if (sv[t]) begin
            acc++;
            t_last = t;
         end
      end
      f0 = (len == 0) ? 1 : t_last + 1;
      d0 = f0 + F;
      q = 0;
      done_t = d0 + DMAX;
      for (int c = d0; c < d0 + DMAX; c++) begin
         q = (lv[c] == 0) ? q + 1 : 0;
         if (q == Q) begin
            done_t = c + 1;
            break;
         end
      end
      timeout = (q != Q);
      abort_t = -1;
      if (ab_mode == 1) abort_t = f0 + 1;
      if (ab_mode == 2) abort_t = int'($urandom_range(done_t - 1, f0));
      if (abort_t >= 0) timeout = 1'b0;
      end_t = (abort_t >= 0) ? abort_t : done_t;

      for (int t = 0; t <= end_t + TAIL; t++) begin
         start     = st[t] && (t <= end_t);
         abort     = (t == abort_t);
         frame_len = fl_in[t];
         src_valid = sv[t];
         lvl_valid = lv[t];
         pt        = t - 1;
         feed_pt   = (len > 0) && (pt >= 1) && (pt <= t_last) && sv[pt];
         flush_pt  = (pt >= f0) && (pt < f0 + F);
         rdy_e     = (len > 0) && (t >= 1) && (t <= t_last) && (t <= end_t);
         dv_e      = (t >= 1) && (pt <= end_t) && (pt != abort_t) && (feed_pt || flush_pt);
         dz_e      = (t >= 1) && (pt <= end_t) && (pt != abort_t) && flush_pt;
         chk("src_ready", 80'(src_ready), 80'(rdy_e));
         chk("busy", 80'(busy), 80'((t >= 1) && (t <= end_t)));
         chk("done", 80'(done), 80'((abort_t < 0) && (t == done_t)));
         chk("din_valid", 80'(din_valid), 80'(dv_e));
         chk("din_zero", 80'(din_zero), 80'(dz_e));
         chk("err_timeout", 80'(err_timeout), 80'(err_exp));
         chk("lvl_cnt", lvl_cnt, exp_cnt(16));
         chk("busy4", 80'(busy4), 80'((t >= 1) && (t <= end_t)));
         chk("done4", 80'(done4), 80'((abort_t < 0) && (t == done_t)));
         chk("din_valid4", 80'(din_valid4), 80'(dv_e));
         chk("err_timeout4", 80'(err_timeout4), 80'(err_exp));
         chk("lvl_cnt4", 80'(lvl_cnt4), exp_cnt(4));
         if (t == 0) begin
            for (int i = 0; i < 5; i++) cnt_exp[i] = 0;
            err_exp = 1'b0;
         end else if (t <= end_t) begin
            for (int i = 0; i < 5; i++) cnt_exp[i] += int'(lv[t][i]);
         end
         if (timeout && (t == done_t - 1)) err_exp = 1'b1;
         @(posedge clk_78_125);
         #1;
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic mid_reset();
      start     = 1'b1;
      frame_len = 16'd2;
      src_valid = 1'b1;
      lvl_valid = 5'b00001;
      @(posedge clk_78_125);
      #1;
      start = 1'b0;
      repeat (14) begin
         @(posedge clk_78_125);
         #1;
      end
      chk("mid_busy", 80'(busy), 80'(1));
      #2;
      rstn = 1'b0;
      #1;
      chk("rst_busy", 80'(busy), 80'(0));
      chk("rst_ready", 80'(src_ready), 80'(0));
      chk("rst_dv", 80'(din_valid), 80'(0));
      chk("rst_dz", 80'(din_zero), 80'(0));
      chk("rst_done", 80'(done), 80'(0));
      chk("rst_err", 80'(err_timeout), 80'(0));
      chk("rst_cnt", lvl_cnt, 80'(0));
      @(posedge clk_78_125);
      #1;
      rstn      = 1'b1;
      lvl_valid = '0;
      src_valid = 1'b0;
      for (int i = 0; i < 5; i++) cnt_exp[i] = 0;
      err_exp = 1'b0;
      @(posedge clk_78_125);
      #1;
   endtask

   initial begin
      rstn      = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      src_valid = 1'b0;
      frame_len = '0;
      lvl_valid = '0;
      err_exp   = 1'b0;
      for (int i = 0; i < 5; i++) cnt_exp[i] = 0;
      #1;
      chk("reset_busy", 80'(busy), 80'(0));
      chk("reset_ready", 80'(src_ready), 80'(0));
      chk("reset_dv", 80'(din_valid), 80'(0));
      chk("reset_dz", 80'(din_zero), 80'(0));
      chk("reset_done", 80'(done), 80'(0));
      chk("reset_err", 80'(err_timeout), 80'(0));
      chk("reset_cnt", lvl_cnt, 80'(0));
      repeat (2) @(posedge clk_78_125);
      #1;
      rstn = 1'b1;
      @(posedge clk_78_125);
      #1;

      run_frame(4, 0, 0, 0, 1'b0);
      run_frame(3, 1, 0, 0, 1'b0);
      run_frame(0, 2, 1, 0, 1'b0);
      run_frame(2, 2, 2, 0, 1'b0);
      chk("err_after_timeout", 80'(err_timeout), 80'(1));
      run_frame(5, 2, 1, 0, 1'b0);
      chk("err_cleared", 80'(err_timeout), 80'(0));
      run_frame(4, 0, 1, 1, 1'b0);
      run_frame(6, 2, 1, 0, 1'b1);
      run_frame(4, 0, 3, 0, 1'b0);
      chk("sat_l5_narrow", 80'(lvl_cnt4[19:16]), 80'(4'hF));
      chk("sat_l5_wide", 80'(lvl_cnt[79:64]), 80'(20));
      mid_reset();
      for (int k = 0; k < 20; k++) begin
         run_frame(int'($urandom_range(0, 12)), 2, 1,
                   ($urandom_range(0, 3) == 0) ? 2 : 0, 1'b1);
      end

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
